// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates LSB loads/stores and instruction fetches onto one byte-wide RAM/IO port.
// Latency: an N-byte access pulses its success flag N+1 cycles after accept, then spends one DONE cycle.
// Backpressure: rdy=0 freezes everything; with IO_STALL_EN defined, IO store bytes wait while io_buffer_full.
module mem_ctrl #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  // LSB side
  input  logic              lsb_read_signal,
  input  logic              lsb_write_signal,
  input  logic [2:0]        requiring_length,
  input  logic [ADDR_W-1:0] to_mem_addr,
  input  logic [DATA_W-1:0] to_mem_data,
  input  logic              load_signed,
  output logic              mem_load_success,
  output logic              mem_store_success,
  output logic [DATA_W-1:0] from_mem_data,
  // fetcher side
  input  logic              fetch_signal,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_success,
  output logic [DATA_W-1:0] fetch_instr,
  // RAM / IO port
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    FETCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_nxt;

  // Latched request and progress
  logic [2:0]        cnt_q;
  logic [2:0]        len_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] buf_q;

  // FSM decode
  logic              acc_ld;
  logic              acc_st;
  logic              acc_fe;
  logic              cnt_inc;
  logic              wr_en;
  logic              ld_done;
  logic              st_done;
  logic              io_stall;
  logic              io_hit;

  // Byte bookkeeping
  logic [1:0]        rd_idx;
  logic [1:0]        wr_idx;
  logic [1:0]        addr_off;
  logic              last_byte;
  logic [DATA_W-1:0] buf_asm;

  // Sign/zero extension of a 1- or 2-byte load; full words pass unchanged.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [2:0]        len,
                                               input logic              sgn);
    logic [DATA_W-1:0] res;
    case (len)
      3'd1:    res = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
      3'd2:    res = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Read byte k arrives one cycle after it was addressed, so on counter value c we capture byte c-1.
  // Store byte k goes out on counter value k+1 (counter 0 is a setup cycle with no write).
  always_comb begin
    rd_idx    = cnt_q[1:0] - 2'd1;
    wr_idx    = (cnt_q == 3'd0) ? 2'd0 : rd_idx;
    last_byte = (cnt_q >= len_q);
  end

  // RAM address offset: reads walk ahead of capture; on the capture-only cycle re-present the last
  // address rather than touching one byte beyond the access (that byte might be IO).
  always_comb begin
    addr_off = 2'd0;
    case (state_q)
      LOAD, FETCH: addr_off = last_byte ? rd_idx : cnt_q[1:0];
      STORE:       addr_off = wr_idx;
      default:     addr_off = 2'd0;
    endcase
  end

  assign mem_a  = addr_q + ADDR_W'(addr_off);
  assign io_hit = (mem_a >= IO_BASE);

`ifdef IO_STALL_EN
  // Hold an IO store byte while the IO output buffer cannot take it.
  assign io_stall = (state_q == STORE) && (cnt_q != 3'd0) && io_hit && io_buffer_full;
`else
  assign io_stall = 1'b0;
  logic unused_io;
  assign unused_io = &{1'b0, io_buffer_full, io_hit};
`endif

  // Select the outgoing store byte, little-endian.
  always_comb begin
    mem_dout = 8'h00;
    if (state_q == STORE) begin
      case (wr_idx)
        2'd0:    mem_dout = data_q[7:0];
        2'd1:    mem_dout = data_q[15:8];
        2'd2:    mem_dout = data_q[23:16];
        default: mem_dout = data_q[31:24];
      endcase
    end
  end

  // Merge the byte currently on mem_din into the assembly buffer.
  always_comb begin
    buf_asm = buf_q;
    if (cnt_q != 3'd0) begin
      case (rd_idx)
        2'd0:    buf_asm[7:0]   = mem_din;
        2'd1:    buf_asm[15:8]  = mem_din;
        2'd2:    buf_asm[23:16] = mem_din;
        default: buf_asm[31:24] = mem_din;
      endcase
    end
  end

  // A write only happens in a live cycle.
  assign mem_wr = wr_en & rdy;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_nxt;
    end
  end

  // Next state and per-cycle control: arbitration in IDLE, byte sequencing, flush handling.
  always_comb begin
    state_nxt = state_q;
    acc_ld    = 1'b0;
    acc_st    = 1'b0;
    acc_fe    = 1'b0;
    cnt_inc   = 1'b0;
    wr_en     = 1'b0;
    ld_done   = 1'b0;
    st_done   = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush cycle accepts nothing; stores outrank loads, loads outrank fetches.
        if (!jump_wrong) begin
          if (lsb_write_signal) begin
            acc_st    = 1'b1;
            state_nxt = STORE;
          end else if (lsb_read_signal) begin
            acc_ld    = 1'b1;
            state_nxt = LOAD;
          end else if (fetch_signal) begin
            acc_fe    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      LOAD, FETCH: begin
        // Speculative reads are simply dropped on a flush.
        if (jump_wrong) begin
          state_nxt = IDLE;
        end else if (last_byte) begin
          ld_done   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STORE: begin
        // Stores are committed, so a flush does not interrupt them.
        if (cnt_q == 3'd0) begin
          cnt_inc = 1'b1;
        end else if (!io_stall) begin
          wr_en = 1'b1;
          if (last_byte) begin
            st_done   = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        // One dead cycle so level-sensitive requesters can drop their request.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latching, byte counter, load assembly and the registered result/pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q             <= 3'd0;
      len_q             <= 3'd0;
      sign_q            <= 1'b0;
      addr_q            <= '0;
      data_q            <= '0;
      buf_q             <= '0;
      from_mem_data     <= '0;
      fetch_instr       <= '0;
      mem_load_success  <= 1'b0;
      mem_store_success <= 1'b0;
      fetch_success     <= 1'b0;
    end else if (rdy) begin
      mem_load_success  <= 1'b0;
      mem_store_success <= 1'b0;
      fetch_success     <= 1'b0;

      if (acc_ld || acc_st) begin
        addr_q <= to_mem_addr;
        len_q  <= requiring_length;
        data_q <= to_mem_data;
        sign_q <= load_signed;
        buf_q  <= '0;
      end else if (acc_fe) begin
        addr_q <= fetch_addr;
        len_q  <= 3'd4;
        sign_q <= 1'b0;
        buf_q  <= '0;
      end

      if (cnt_inc) begin
        cnt_q <= cnt_q + 3'd1;
      end else if (state_nxt != state_q) begin
        cnt_q <= 3'd0;
      end

      if ((state_q == LOAD || state_q == FETCH) && !jump_wrong && cnt_q != 3'd0) begin
        buf_q <= buf_asm;
      end

      if (ld_done) begin
        if (state_q == LOAD) begin
          from_mem_data    <= extend(buf_asm, len_q, sign_q);
          mem_load_success <= 1'b1;
        end else begin
          fetch_instr   <= buf_asm;
          fetch_success <= 1'b1;
        end
      end

      if (st_done) begin
        mem_store_success <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboarded bench for mem_ctrl against a byte-wide RAM model.
// Inputs change 2 ns after posedge; outputs are sampled on negedge.
// Expected loads, fetches and write bytes are queued at issue and popped when the DUT produces them.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_wrong;
  logic        lsb_read_signal;
  logic        lsb_write_signal;
  logic [2:0]  requiring_length;
  logic [31:0] to_mem_addr;
  logic [31:0] to_mem_data;
  logic        load_signed;
  logic        mem_load_success;
  logic        mem_store_success;
  logic [31:0] from_mem_data;
  logic        fetch_signal;
  logic [31:0] fetch_addr;
  logic        fetch_success;
  logic [31:0] fetch_instr;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .jump_wrong        (jump_wrong),
    .lsb_read_signal   (lsb_read_signal),
    .lsb_write_signal  (lsb_write_signal),
    .requiring_length  (requiring_length),
    .to_mem_addr       (to_mem_addr),
    .to_mem_data       (to_mem_data),
    .load_signed       (load_signed),
    .mem_load_success  (mem_load_success),
    .mem_store_success (mem_store_success),
    .from_mem_data     (from_mem_data),
    .fetch_signal      (fetch_signal),
    .fetch_addr        (fetch_addr),
    .fetch_success     (fetch_success),
    .fetch_instr       (fetch_instr),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
    logic [31:0] k;
  } wr_t;

  logic [7:0]  ram [0:4095];
  logic [31:0] exp_load [$];
  logic [31:0] exp_fetch [$];
  wr_t         exp_wr [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc = 0;
  int n_ld = 0;
  int n_st = 0;
  int n_fe = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM model: one-cycle read latency; it holds its output while the system is frozen.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every write byte and success pulse.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (mem_wr) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", exp_wr.size(), 1);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", mem_a, e.a);
          check("wr_data", {24'h0, mem_dout}, {24'h0, e.d});
          check("wr_cycle", cyc - acc, e.k);
        end
      end
      if (int'(mem_load_success) + int'(mem_store_success) + int'(fetch_success) > 1)
        check("pulse_excl", int'(mem_load_success) + int'(mem_store_success) + int'(fetch_success), 1);
      if (mem_load_success) begin
        n_ld++;
        if (exp_load.size() == 0) check("load_unexpected", exp_load.size(), 1);
        else check("load_data", from_mem_data, exp_load.pop_front());
      end
      if (fetch_success) begin
        n_fe++;
        if (exp_fetch.size() == 0) check("fetch_unexpected", exp_fetch.size(), 1);
        else check("fetch_instr", fetch_instr, exp_fetch.pop_front());
      end
      if (mem_store_success) n_st++;
    end
  end

  // Issue one request (0 load, 1 store, 2 fetch) and return the pulse cycle relative to accept.
  task automatic run_req(input int op, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] len, input logic sgn, output int k);
    k = -1;
    case (op)
      0: begin lsb_read_signal = 1'b1; to_mem_addr = a; requiring_length = len; load_signed = sgn; end
      1: begin lsb_write_signal = 1'b1; to_mem_addr = a; to_mem_data = d; requiring_length = len; end
      default: begin fetch_signal = 1'b1; fetch_addr = a; end
    endcase
    @(posedge clk);
    acc = cyc + 1;
    for (int i = 0; i < 40 && k < 0; i++) begin
      @(negedge clk);
      if ((op == 0 && mem_load_success) || (op == 1 && mem_store_success) ||
          (op == 2 && fetch_success))
        k = cyc - acc;
    end
    @(posedge clk); #2;
    lsb_read_signal  = 1'b0;
    lsb_write_signal = 1'b0;
    fetch_signal     = 1'b0;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input int len, input int k0);
    for (int i = 0; i < len; i++)
      exp_wr.push_back('{a: a + 32'(i), d: d[8*i +: 8], k: 32'(k0 + i)});
  endtask

  initial begin
    int k;
    int kl;
    int kf;
    int n0;
    int n1;
    int k_io;
    int lat_io;

    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
    lsb_read_signal = 1'b0; lsb_write_signal = 1'b0; requiring_length = 3'd0;
    to_mem_addr = '0; to_mem_data = '0; load_signed = 1'b0;
    fetch_signal = 1'b0; fetch_addr = '0; io_buffer_full = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33;
    ram[12'h103] = 8'h44; ram[12'h104] = 8'h55;
    ram[12'h200] = 8'h80;
    ram[12'h210] = 8'hFF; ram[12'h211] = 8'h7F;
    ram[12'h212] = 8'h01; ram[12'h213] = 8'h80;
    ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h12;

    repeat (3) @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    check("rst_from_mem_data", from_mem_data, 32'h0);
    check("rst_fetch_instr", fetch_instr, 32'h0);
    check("rst_pulses", {29'h0, mem_load_success, mem_store_success, fetch_success}, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;

    // Loads of every width, signed and unsigned, aligned, unaligned and wrapping.
    exp_load.push_back(32'h4433_2211); run_req(0, 32'h100, 0, 3'd4, 1'b0, k); check("lw_lat", k, 5);
    exp_load.push_back(32'hFFFF_FF80); run_req(0, 32'h200, 0, 3'd1, 1'b1, k); check("lb_lat", k, 2);
    exp_load.push_back(32'h0000_0080); run_req(0, 32'h200, 0, 3'd1, 1'b0, k); check("lbu_lat", k, 2);
    exp_load.push_back(32'h0000_7FFF); run_req(0, 32'h210, 0, 3'd2, 1'b1, k); check("lh_lat", k, 3);
    exp_load.push_back(32'hFFFF_8001); run_req(0, 32'h212, 0, 3'd2, 1'b1, k); check("lh_neg_lat", k, 3);
    exp_load.push_back(32'h0000_8001); run_req(0, 32'h212, 0, 3'd2, 1'b0, k); check("lhu_lat", k, 3);
    exp_load.push_back(32'h5544_3322); run_req(0, 32'h101, 0, 3'd4, 1'b0, k); check("lw_unal_lat", k, 5);
    exp_load.push_back(32'h0000_1234); run_req(0, 32'hFFFF_FFFF, 0, 3'd2, 1'b0, k); check("lh_wrap_lat", k, 3);

    // Instruction fetch.
    exp_fetch.push_back(32'h4433_2211); run_req(2, 32'h100, 0, 3'd4, 1'b0, k); check("fetch_lat", k, 5);

    // Halfword store, then read it back.
    push_store(32'h300, 32'h0000_ABCD, 2, 1);
    run_req(1, 32'h300, 32'h0000_ABCD, 3'd2, 1'b0, k); check("sh_lat", k, 3);
    exp_load.push_back(32'h0000_ABCD); run_req(0, 32'h300, 0, 3'd4, 1'b0, k); check("sh_rb_lat", k, 5);

    // Load and fetch raised together: load first, DONE cycle, then the fetch exactly once.
    n0 = n_fe; n1 = n_ld; kl = -1; kf = -1;
    exp_load.push_back(32'h4433_2211); exp_fetch.push_back(32'h5544_3322);
    lsb_read_signal = 1'b1; to_mem_addr = 32'h100; requiring_length = 3'd4; load_signed = 1'b0;
    fetch_signal = 1'b1; fetch_addr = 32'h101;
    @(posedge clk); acc = cyc + 1;
    for (int i = 0; i < 40 && kf < 0; i++) begin
      @(negedge clk);
      if (mem_load_success) kl = cyc - acc;
      if (fetch_success) kf = cyc - acc;
      if (kf < 0) begin
        @(posedge clk); #2;
        if (kl >= 0) lsb_read_signal = 1'b0;
      end
    end
    @(posedge clk); #2 fetch_signal = 1'b0; lsb_read_signal = 1'b0;
    repeat (6) @(posedge clk); #2;
    check("both_load_lat", kl, 5);
    check("both_fetch_lat", kf, 12);
    check("both_fetch_once", n_fe - n0, 1);
    check("both_load_once", n_ld - n1, 1);

    // rdy low for two edges mid-load stretches the latency by two.
    fork
      begin repeat (3) @(posedge clk); #2 rdy = 1'b0; repeat (2) @(posedge clk); #2 rdy = 1'b1; end
    join_none
    exp_load.push_back(32'h4433_2211); run_req(0, 32'h100, 0, 3'd4, 1'b0, k); check("rdy_freeze_lat", k, 7);

    // Flush during fetch byte 2: no fetch pulse, controller idle for an immediate load.
    n0 = n_fe;
    fetch_signal = 1'b1; fetch_addr = 32'h100;
    repeat (3) @(posedge clk); #2 jump_wrong = 1'b1; fetch_signal = 1'b0;
    @(posedge clk); #2 jump_wrong = 1'b0;
    exp_load.push_back(32'h4433_2211); run_req(0, 32'h100, 0, 3'd4, 1'b0, k); check("jw_fetch_then_lw", k, 5);
    check("jw_fetch_none", n_fe - n0, 0);

    // Flush while idle blocks acceptance for that edge.
    jump_wrong = 1'b1;
    fork
      begin @(posedge clk); #2 jump_wrong = 1'b0; end
    join_none
    exp_load.push_back(32'h0000_0080); run_req(0, 32'h200, 0, 3'd1, 1'b0, k); check("jw_idle_lat", k, 3);

    // Flush during a word store: all four bytes still land and the store pulses.
    push_store(32'h400, 32'h1234_5678, 4, 1);
    fork
      begin repeat (2) @(posedge clk); #2 jump_wrong = 1'b1; @(posedge clk); #2 jump_wrong = 1'b0; end
    join_none
    run_req(1, 32'h400, 32'h1234_5678, 3'd4, 1'b0, k); check("jw_sw_lat", k, 5);
    exp_load.push_back(32'h1234_5678); run_req(0, 32'h400, 0, 3'd4, 1'b0, k); check("sw_rb_lat", k, 5);

    // Byte store to IO space while the IO buffer reports full.
`ifdef IO_STALL_EN
    k_io = 4; lat_io = 5;
`else
    k_io = 1; lat_io = 2;
`endif
    n0 = n_st;
    io_buffer_full = 1'b1;
    push_store(32'h0003_0000, 32'h0000_005A, 1, k_io);
    fork
      begin repeat (5) @(posedge clk); #2 io_buffer_full = 1'b0; end
    join_none
    run_req(1, 32'h0003_0000, 32'h0000_005A, 3'd1, 1'b0, k); check("io_sb_lat", k, lat_io);
    repeat (4) @(posedge clk); #2;
    check("io_sb_once", n_st - n0, 1);

    check("load_q_empty", exp_load.size(), 0);
    check("fetch_q_empty", exp_fetch.size(), 0);
    check("wr_q_empty", exp_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
